mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequential front-end controller for the team's 8:1 gate-level multiplexer (8 data inputs, selects s0/s1/s2, output Y).
- Steps the mux select lines through all 8 channels and samples Y once per channel. Assembles the 8 samples into a parallel word.
- Presents the word with a one-cycle valid strobe and supports single-shot or continuous scanning.

Parameters:
- SETTLE_CYCLES, 1, cycles each channel's select is held before Y is sampled; legal range 1..15.
- NUM_CH, 8, channel count; fixed at 8, not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  when high at end of a scan, restart immediately at channel 0.
- y_in  input  1  mux output Y; sampled only in SAMPLE state.
- s0  output  1  mux select, registered; equals ch[2].
- s1  output  1  mux select, registered; equals ch[1].
- s2  output  1  mux select, registered; equals ch[0].
- data_out  output  8  last completed scan; bit k = sample of channel k.
- valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst). No asynchronous logic.
- Select mapping: the mux routes I1 when s2=1 and s1=s0=0, so s2 carries the channel LSB and s0 the MSB.
  - The mux therefore passes I[ch] for {s0,s1,s2} = {ch[2],ch[1],ch[0]}.
  - This mapping is mandatory.
- Reset values: state=IDLE, ch=0, s0=s1=s2=0, data_out=8'h00, valid=0, busy=0, settle counter=0, shadow register=0.
- IDLE:
  - Selects hold channel 0.
  - start=1 → SETTLE, ch=0, counter=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (1 cycle):
  - shadow[ch] <= y_in.
  - If ch==7 → DONE; else ch<=ch+1, counter<=0, → SETTLE.
- DONE (1 cycle):
  - data_out <= shadow, using the bit-7 value captured in the preceding SAMPLE.
  - valid=1 for exactly this cycle.
  - If continuous=1 → SETTLE with ch=0, counter=0; else → IDLE with ch=0.
- Latency: with start high at edge E, valid is high in cycle E+8*(SETTLE_CYCLES+1)+1.
  - SETTLE_CYCLES=1: 17 cycles. In continuous mode, consecutive valid pulses are 8*(SETTLE_CYCLES+1)+1 cycles apart.
- Selects change only on the edge that enters SETTLE. They are stable through SETTLE and SAMPLE of that channel.
- start while busy: ignored, no queuing.
- start and rst high together: rst wins.
- continuous may toggle at any time; only its value in the DONE cycle matters.
- rst mid-scan: abort at the next edge; all outputs return to reset values; partial shadow is discarded.
- data_out holds its value between valid pulses. An aborted scan never updates data_out.
- ch is 3 bits; the 7→0 wrap happens only via DONE, never by free increment.

Decomposition:
- Shared package/include mux_scan_pkg:
  - state encoding IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - CH_W=3, NUM_CH=8, CNT_W=4.
- One natural sub-module: mux_sel_map, purely combinational, ch[2:0] → {s0,s1,s2}. It isolates the bit-reversed select mapping so it is tested once.
- Output registers stay in the top-level FSM.

Test Plan:
- Reset: hold rst 2 cycles with start=1 → data_out=8'h00, valid=0, busy=0, s0=s1=s2=0 throughout.
- Single scan: behavioural 8:1 mux on I=8'hA6, SETTLE_CYCLES=1, pulse start → valid exactly 17 cycles after the start edge; data_out=8'hA6; busy falls the cycle after valid.
- Select sweep: during that scan, record {s0,s1,s2} at each SAMPLE cycle → sequence 000,001,010,011,100,101,110,111 at channels 0..7.
- Continuous: continuous=1, I=8'h3C, then I=8'hC3 changed after the first valid → two valid pulses 17 cycles apart, carrying 8'h3C then 8'hC3; drop continuous → IDLE after the second.
- Abort: start a scan with I=8'hFF over prior data_out=8'hA6, assert rst at cycle 9 → next cycle data_out=8'h00, busy=0, no valid pulse.
- start while busy: pulse start again at cycle 5 of a scan → exactly one valid pulse; SETTLE_CYCLES=3 run gives valid at cycle 33.

Source files
------------

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_pkg
// Purpose  : Shared constants for the 8:1 mux scan controller: channel and
//            settle-counter widths, channel count, and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int CH_W   = 3;  // channel index width
  localparam int NUM_CH = 8;  // mux channel count, fixed by the target mux
  localparam int CNT_W  = 4;  // settle counter width (SETTLE_CYCLES <= 15)

  // Scan FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_sel_map.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_map
// Purpose  : Maps a channel index onto the gate-level mux select pins.
//            The mux routes I1 for s2=1, s1=s0=0, so s2 is the channel LSB
//            and s0 the MSB: {s0,s1,s2} = {ch[2],ch[1],ch[0]}.
// Ports    : i_ch  [CH_W-1:0]  channel index
//            o_s0              select, channel bit 2
//            o_s1              select, channel bit 1
//            o_s2              select, channel bit 0
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_map
  import mux_scan_pkg::*;
(
  input  logic [CH_W-1:0] i_ch,
  output logic            o_s0,
  output logic            o_s1,
  output logic            o_s2
);

  assign o_s0 = i_ch[2];
  assign o_s1 = i_ch[1];
  assign o_s2 = i_ch[0];

endmodule : mux_sel_map
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Steps the 8:1 mux through channels 0..7, holds each select for
//            SETTLE_CYCLES cycles, samples Y once per channel and presents
//            the assembled byte with a one-cycle valid strobe. Supports
//            single-shot and continuous scanning.
// Params   : SETTLE_CYCLES  cycles a select is held before sampling (1..15)
// Ports    : clk         system clock, rising edge
//            rst         synchronous active-high reset
//            start       begin a scan (honoured only in IDLE)
//            continuous  restart at channel 0 when high in the DONE cycle
//            y_in        mux output Y
//            s0/s1/s2    registered mux selects ({s0,s1,s2} = ch)
//            data_out    last completed scan, bit k = channel k
//            valid       one-cycle strobe in the DONE cycle
//            busy        high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              y_in,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic [NUM_CH-1:0] data_out,
  output logic              valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  c_LAST_CH     = CH_W'(NUM_CH - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] r_data;
  logic              r_s0;
  logic              r_s1;
  logic              r_s2;
  logic              w_s0_nxt;
  logic              w_s1_nxt;
  logic              w_s2_nxt;

  // Selects are derived from the next channel index and registered, so they
  // move on exactly the edge where the channel index moves.
  mux_sel_map u_sel_map (
    .i_ch (w_ch_nxt),
    .o_s0 (w_s0_nxt),
    .o_s1 (w_s1_nxt),
    .o_s2 (w_s2_nxt)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s0    <= w_s0_nxt;
      r_s1    <= w_s1_nxt;
      r_s2    <= w_s2_nxt;
      if (r_state == SAMPLE) begin
        r_shadow[r_ch] <= y_in;
      end
      // Shadow already holds bit 7 from the SAMPLE cycle just before DONE.
      if (r_state == DONE) begin
        r_data <= r_shadow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_ch_nxt = '0;
        if (start) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_SETTLE_LAST) begin
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        // Channel 7 is never incremented here; the wrap to 0 happens in DONE.
        if (r_ch == c_LAST_CH) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SETTLE;
          w_ch_nxt    = r_ch + 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      DONE: begin
        w_ch_nxt    = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = continuous ? SETTLE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ch_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore outputs from registered state)
  // --------------------------------------------------------------------------
  always_comb begin
    valid    = (r_state == DONE);
    busy     = (r_state != IDLE);
    s0       = r_s0;
    s1       = r_s1;
    s2       = r_s2;
    data_out = r_data;
  end

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Self-checking bench for mux_scan_ctrl. A behavioural 8:1 mux
//            drives y_in from the DUT selects. One instance uses
//            SETTLE_CYCLES=1, a second uses SETTLE_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       continuous;
  logic       y_in;
  logic       s0, s1, s2;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;

  logic       start3;
  logic       y3;
  logic       s0_3, s1_3, s2_3;
  logic [7:0] data3;
  logic       valid3;
  logic       busy3;

  logic [7:0] r_pat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp_d;
    logic       chk_sel;
  } vec_t;

  vec_t vecs [5];

  // Behavioural 8:1 mux: passes I[{s0,s1,s2}]
  assign y_in = r_pat[{s0, s1, s2}];
  assign y3   = r_pat[{s0_3, s1_3, s2_3}];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .y_in       (y_in),
    .s0         (s0),
    .s1         (s1),
    .s2         (s2),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .continuous (1'b0),
    .y_in       (y3),
    .s0         (s0_3),
    .s1         (s1_3),
    .s2         (s2_3),
    .data_out   (data3),
    .valid      (valid3),
    .busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single-shot scan on the SETTLE_CYCLES=1 instance. Called at a negedge.
  // Cycle n is the period after the n-th rising edge counted from the start edge.
  task automatic run_scan1(input logic [7:0] pat, input logic [7:0] exp_d, input logic chk_sel);
    int lat;
    int np;
    lat = 0;
    np  = 0;
    r_pat = pat;
    continuous = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      // With one settle cycle, channel k is sampled in cycle 2k+2.
      if (chk_sel && (n % 2 == 0) && n <= 16)
        chk("sel_sweep", {29'd0, s0, s1, s2}, (n / 2) - 1);
      if (valid) begin
        np++;
        if (lat == 0) begin
          lat = n;
          chk("busy_at_valid", {31'd0, busy}, 1);
        end
      end
      if (lat != 0 && n == lat + 1) begin
        chk("data_out", {24'd0, data_out}, {24'd0, exp_d});
        chk("busy_after_valid", {31'd0, busy}, 0);
      end
    end
    chk("latency", lat, 17);
    chk("valid_pulses", np, 1);
  endtask

  initial begin
    int v1, v2, np, lat3;

    vecs[0] = '{pat: 8'hA6, exp_d: 8'hA6, chk_sel: 1'b1};
    vecs[1] = '{pat: 8'h5A, exp_d: 8'h5A, chk_sel: 1'b0};
    vecs[2] = '{pat: 8'h01, exp_d: 8'h01, chk_sel: 1'b0};
    vecs[3] = '{pat: 8'h80, exp_d: 8'h80, chk_sel: 1'b0};
    vecs[4] = '{pat: 8'hA6, exp_d: 8'hA6, chk_sel: 1'b0};

    r_pat      = 8'h00;
    rst        = 1'b1;
    start      = 1'b1;
    start3     = 1'b0;
    continuous = 1'b0;

    // Reset with start held high: reset must win
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_data",  {24'd0, data_out}, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_busy",  {31'd0, busy}, 0);
      chk("rst_sel",   {29'd0, s0, s1, s2}, 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // Table-driven single scans; the last one leaves data_out=8'hA6
    for (int k = 0; k < 5; k++) begin
      run_scan1(vecs[k].pat, vecs[k].exp_d, vecs[k].chk_sel);
      chk("idle_sel", {29'd0, s0, s1, s2}, 0);
    end

    // Continuous: 3C then C3, drop continuous before the second DONE
    v1 = 0; v2 = 0; np = 0;
    r_pat = 8'h3C;
    continuous = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (valid) begin
        np++;
        if (v1 == 0) begin
          v1 = n;
          r_pat = 8'hC3;
        end else if (v2 == 0) begin
          v2 = n;
        end
      end
      if (v1 != 0 && n == v1 + 1) begin
        chk("cont_data1", {24'd0, data_out}, 32'h3C);
        chk("cont_busy1", {31'd0, busy}, 1);
      end
      if (v1 != 0 && n == v1 + 5) continuous = 1'b0;
      if (v2 != 0 && n == v2 + 1) begin
        chk("cont_data2", {24'd0, data_out}, 32'hC3);
        chk("cont_busy2", {31'd0, busy}, 0);
      end
    end
    chk("cont_first_latency", v1, 17);
    chk("cont_spacing", v2 - v1, 17);
    chk("cont_pulses", np, 2);

    // Abort: prime data_out=A6, then reset mid-scan of FF
    run_scan1(8'hA6, 8'hA6, 1'b0);
    np = 0;
    r_pat = 8'hFF;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (valid) np++;
      if (n == 9) rst = 1'b1;
      if (n == 10) begin
        chk("abort_data",  {24'd0, data_out}, 0);
        chk("abort_busy",  {31'd0, busy}, 0);
        chk("abort_sel",   {29'd0, s0, s1, s2}, 0);
        chk("abort_valid", {31'd0, valid}, 0);
        rst = 1'b0;
      end
    end
    chk("abort_pulses", np, 0);
    chk("abort_data_hold", {24'd0, data_out}, 0);

    // start while busy on the SETTLE_CYCLES=3 instance
    np = 0; lat3 = 0;
    r_pat = 8'h5A;
    start3 = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) start3 = 1'b0;
      if (n == 5) start3 = 1'b1;
      if (n == 6) start3 = 1'b0;
      if (valid3) begin
        np++;
        if (lat3 == 0) lat3 = n;
      end
      if (lat3 != 0 && n == lat3 + 1) begin
        chk("s3_data", {24'd0, data3}, 32'h5A);
        chk("s3_busy_after", {31'd0, busy3}, 0);
      end
    end
    chk("s3_latency", lat3, 33);
    chk("s3_pulses", np, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
